mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous memory between the CPU instruction-fetch port and data port, so the core runs from a unified RAM.
- Arbitrates per cycle and issues the winning access to the memory in the same cycle.
- Tracks in-flight accesses in a tag pipeline and routes each response back to the requester that issued it.
- Sits between the core's imem/dmem ports and the RAM macro.

---
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port synchronous RAM between the instruction
//               fetch and data ports; tags in-flight accesses for response routing.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int MEM_LATENCY   = 1,
  parameter int DATA_PRIORITY = 1,
  parameter int STARVE_LIMIT  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_we,
  output logic        d_ready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_d,
  output logic [3:0]  mem_we,
  input  logic [31:0] mem_q
);

  localparam logic [3:0] c_starve_max = 4'(STARVE_LIMIT);

  logic                   w_conflict;
  logic                   w_grant_d;
  logic                   w_grant_i;
  logic                   w_issue;
  logic                   w_unused;

  logic [3:0]             starve_q, starve_d;
  logic                   rr_last_i_q, rr_last_i_d;
  logic [MEM_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [MEM_LATENCY-1:0] tag_dat_q, tag_dat_d;
  logic [MEM_LATENCY-1:0] tag_wr_q,  tag_wr_d;

  assign w_unused = ^{i_addr[1:0], d_addr[1:0]};

  // Arbitration: rr_last_i_q remembers who won the last conflict, so the
  // reset value (instruction) hands the first conflict to the data port.
  always_comb begin
    w_conflict = i_req & d_req;
    w_grant_d  = d_req;
    if (w_conflict) begin
      if (DATA_PRIORITY != 0) begin
        w_grant_d = (starve_q != c_starve_max);
      end else begin
        w_grant_d = rr_last_i_q;
      end
    end
    w_grant_i = i_req & ~w_grant_d;
    w_issue   = i_req | d_req;
  end

  always_comb begin
    starve_d    = starve_q;
    rr_last_i_d = rr_last_i_q;
    if (w_grant_i) begin
      starve_d = 4'd0;
    end else if (w_conflict && (starve_q != c_starve_max)) begin
      starve_d = starve_q + 4'd1;
    end
    if (w_conflict) begin
      rr_last_i_d = w_grant_i;
    end
  end

  always_comb begin
    tag_vld_d    = tag_vld_q << 1;
    tag_dat_d    = tag_dat_q << 1;
    tag_wr_d     = tag_wr_q << 1;
    tag_vld_d[0] = w_issue;
    tag_dat_d[0] = w_grant_d;
    tag_wr_d[0]  = w_grant_d & (|d_we);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q    <= 4'd0;
      rr_last_i_q <= 1'b1;
      tag_vld_q   <= '0;
      tag_dat_q   <= '0;
      tag_wr_q    <= '0;
    end else begin
      starve_q    <= starve_d;
      rr_last_i_q <= rr_last_i_d;
      tag_vld_q   <= tag_vld_d;
      tag_dat_q   <= tag_dat_d;
      tag_wr_q    <= tag_wr_d;
    end
  end

  // Issue outputs are combinational, so they are explicitly held low in reset.
  always_comb begin
    i_ready  = ~rst & w_grant_i;
    d_ready  = ~rst & w_grant_d;
    mem_en   = ~rst & w_issue;
    mem_addr = 32'd0;
    mem_d    = 32'd0;
    mem_we   = 4'd0;
    if (d_ready) begin
      mem_addr = {d_addr[31:2], 2'b00};
      mem_d    = d_wdata;
      mem_we   = d_we;
    end else if (i_ready) begin
      mem_addr = {i_addr[31:2], 2'b00};
    end
  end

  always_comb begin
    i_rvalid = tag_vld_q[MEM_LATENCY-1] & ~tag_dat_q[MEM_LATENCY-1];
    d_rvalid = tag_vld_q[MEM_LATENCY-1] &  tag_dat_q[MEM_LATENCY-1];
    i_rdata  = i_rvalid ? mem_q : 32'd0;
    d_rdata  = (d_rvalid && !tag_wr_q[MEM_LATENCY-1]) ? mem_q : 32'd0;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Three arbiter instances (ML1/prio, ML2/round-robin, ML3/prio
//               limit 2) with behavioural RAMs, directed and random checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req    [3];
  logic [31:0] i_addr   [3];
  logic        i_ready  [3];
  logic        i_rvalid [3];
  logic [31:0] i_rdata  [3];
  logic        d_req    [3];
  logic [31:0] d_addr   [3];
  logic [31:0] d_wdata  [3];
  logic [3:0]  d_we     [3];
  logic        d_ready  [3];
  logic        d_rvalid [3];
  logic [31:0] d_rdata  [3];
  logic        mem_en   [3];
  logic [31:0] mem_addr [3];
  logic [31:0] mem_d    [3];
  logic [3:0]  mem_we   [3];
  logic [31:0] mem_q    [3];

  logic [31:0] ram   [3][4096];
  logic [31:0] qline [3][4];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  // reference-model state for the random test
  int          starve [3];
  logic        rr_i   [3];
  logic        acc_i  [3];
  logic        acc_d  [3];
  logic        rv     [3][8];
  logic        rs     [3][8];
  logic [31:0] rd     [3][8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int ML = g + 1;
    localparam int DP = (g == 1) ? 0 : 1;
    localparam int SL = (g == 2) ? 2 : 3;
    mem_port_arbiter #(.MEM_LATENCY(ML), .DATA_PRIORITY(DP), .STARVE_LIMIT(SL)) u_dut (
      .clk(clk), .rst(rst),
      .i_req(i_req[g]), .i_addr(i_addr[g]), .i_ready(i_ready[g]),
      .i_rvalid(i_rvalid[g]), .i_rdata(i_rdata[g]),
      .d_req(d_req[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]), .d_we(d_we[g]),
      .d_ready(d_ready[g]), .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]),
      .mem_en(mem_en[g]), .mem_addr(mem_addr[g]), .mem_d(mem_d[g]),
      .mem_we(mem_we[g]), .mem_q(mem_q[g])
    );
    assign mem_q[g] = qline[g][ML-1];
  end

  // Behavioural RAM: reads before writing, data appears MEM_LATENCY cycles later;
  // idle slots carry junk so ungated rdata would show up.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      for (int j = 3; j > 0; j--) qline[k][j] <= qline[k][j-1];
      if (mem_en[k]) begin
        qline[k][0] <= ram[k][mem_addr[k][13:2]];
        for (int b = 0; b < 4; b++)
          if (mem_we[k][b]) ram[k][mem_addr[k][13:2]][8*b +: 8] = mem_d[k][8*b +: 8];
      end else begin
        qline[k][0] <= $urandom;
      end
    end
  end

  function automatic int ml_of(int k); return k + 1; endfunction
  function automatic bit dp_of(int k); return k != 1; endfunction
  function automatic int sl_of(int k); return (k == 2) ? 2 : 3; endfunction

  function automatic logic [136:0] all_out(int k);
    return {i_ready[k], i_rvalid[k], i_rdata[k], d_ready[k], d_rvalid[k], d_rdata[k],
            mem_en[k], mem_addr[k], mem_d[k], mem_we[k]};
  endfunction

  task automatic clear_inputs();
    for (int k = 0; k < 3; k++) begin
      i_req[k] = 0; i_addr[k] = 0; d_req[k] = 0; d_addr[k] = 0; d_wdata[k] = 0; d_we[k] = 0;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (all_out(k) !== '0) begin
        bad++; $display("FAIL reset_idle k=%0d got=%h exp=0", k, all_out(k));
      end
    end
    for (int k = 0; k < 3; k++) begin
      i_req[k] = 1; i_addr[k] = 32'h44; d_req[k] = 1; d_addr[k] = 32'h88;
      d_we[k] = 4'hF; d_wdata[k] = 32'hDEADBEEF;
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (all_out(k) !== '0) begin
        bad++; $display("FAIL reset_with_req k=%0d got=%h exp=0", k, all_out(k));
      end
    end
    clear_inputs();
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        total++;
        if (all_out(k) !== '0) begin
          bad++; $display("FAIL post_reset_idle k=%0d c=%0d got=%h exp=0", k, c, all_out(k));
        end
      end
    end
  endtask

  task automatic test_solo_fetch();
    ram[0][12'h041] = 32'h00A00093;
    next_cycle();
    i_req[0] = 1; i_addr[0] = 32'h104;
    @(negedge clk);
    total++;
    if ({i_ready[0], d_ready[0], mem_en[0], mem_we[0], mem_addr[0]} !== {3'b101, 4'h0, 32'h104}) begin
      bad++;
      $display("FAIL solo_issue got rdy_i=%b rdy_d=%b en=%b we=%h addr=%h exp 1 0 1 0 00000104",
               i_ready[0], d_ready[0], mem_en[0], mem_we[0], mem_addr[0]);
    end
    next_cycle();
    i_req[0] = 0;
    @(negedge clk);
    total++;
    if ({i_rvalid[0], i_rdata[0], d_rvalid[0]} !== {1'b1, 32'h00A00093, 1'b0}) begin
      bad++;
      $display("FAIL solo_resp got v=%b data=%h dv=%b exp v=1 data=00a00093 dv=0",
               i_rvalid[0], i_rdata[0], d_rvalid[0]);
    end
    @(negedge clk);
    total++;
    if ({i_rvalid[0], i_rdata[0]} !== 33'd0) begin
      bad++; $display("FAIL solo_after got v=%b data=%h exp 0", i_rvalid[0], i_rdata[0]);
    end
  endtask

  task automatic test_data_priority();
    logic [7:0] pat;
    pat = 8'h77;
    next_cycle();
    i_req[0] = 1; i_addr[0] = 32'h100; d_req[0] = 1; d_addr[0] = 32'h2003; d_we[0] = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total++;
      if ({i_ready[0], d_ready[0]} !== (pat[c] ? 2'b01 : 2'b10)) begin
        bad++; $display("FAIL prio_grant c=%0d got i=%b d=%b exp d=%b", c, i_ready[0], d_ready[0], pat[c]);
      end
      total++;
      if (mem_addr[0] !== (pat[c] ? 32'h2000 : 32'h100)) begin
        bad++; $display("FAIL prio_addr c=%0d got=%h exp=%h", c, mem_addr[0], pat[c] ? 32'h2000 : 32'h100);
      end
      next_cycle();
    end
    clear_inputs();
    repeat (3) next_cycle();
  endtask

  task automatic test_round_robin();
    logic hist [8];
    logic s;
    ram[1][12'h080] = 32'h11111111;
    ram[1][12'h100] = 32'h22222222;
    next_cycle();
    i_req[1] = 1; i_addr[1] = 32'h200; d_req[1] = 1; d_addr[1] = 32'h400; d_we[1] = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      hist[c] = (c % 2 == 0);
      total++;
      if (c < 6) begin
        if ({i_ready[1], d_ready[1]} !== (hist[c] ? 2'b01 : 2'b10)) begin
          bad++; $display("FAIL rr_grant c=%0d got i=%b d=%b exp d=%b", c, i_ready[1], d_ready[1], hist[c]);
        end
      end else if ({i_ready[1], d_ready[1], mem_en[1]} !== 3'b000) begin
        bad++; $display("FAIL rr_idle c=%0d got i=%b d=%b en=%b exp 0", c, i_ready[1], d_ready[1], mem_en[1]);
      end
      total++;
      if (c >= 2) begin
        s = hist[c-2];
        if ({i_rvalid[1], d_rvalid[1], i_rdata[1], d_rdata[1]} !==
            {!s, s, (s ? 32'h0 : 32'h11111111), (s ? 32'h22222222 : 32'h0)}) begin
          bad++;
          $display("FAIL rr_resp c=%0d got iv=%b dv=%b id=%h dd=%h exp src_d=%b",
                   c, i_rvalid[1], d_rvalid[1], i_rdata[1], d_rdata[1], s);
        end
      end else if ({i_rvalid[1], d_rvalid[1]} !== 2'b00) begin
        bad++; $display("FAIL rr_early c=%0d got iv=%b dv=%b exp 0", c, i_rvalid[1], d_rvalid[1]);
      end
      next_cycle();
      if (c == 5) clear_inputs();
    end
  endtask

  task automatic test_write_ack();
    ram[2][12'hC01] = 32'h11223344;
    next_cycle();
    d_req[2] = 1; d_addr[2] = 32'h3006; d_we[2] = 4'b0100; d_wdata[2] = 32'h00AB0000;
    @(negedge clk);
    total++;
    if ({d_ready[2], mem_we[2], mem_addr[2], mem_d[2]} !== {1'b1, 4'b0100, 32'h3004, 32'h00AB0000}) begin
      bad++;
      $display("FAIL wr_issue got rdy=%b we=%b addr=%h d=%h exp 1 0100 00003004 00ab0000",
               d_ready[2], mem_we[2], mem_addr[2], mem_d[2]);
    end
    next_cycle();
    clear_inputs();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      total++;
      if ({d_rvalid[2], d_rdata[2], i_rvalid[2]} !== {(c == 3), 32'h0, 1'b0}) begin
        bad++;
        $display("FAIL wr_ack c=%0d got dv=%b dd=%h iv=%b exp dv=%b dd=0", c, d_rvalid[2], d_rdata[2],
                 i_rvalid[2], (c == 3));
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_midflight();
    ram[2][12'h00C] = 32'hCAFEF00D;
    i_req[2] = 1; i_addr[2] = 32'h10;
    @(negedge clk);
    total++;
    if (i_ready[2] !== 1'b1) begin
      bad++; $display("FAIL mid_issue_i got=%b exp=1", i_ready[2]);
    end
    next_cycle();
    i_req[2] = 0; d_req[2] = 1; d_addr[2] = 32'h20; d_we[2] = 0;
    @(negedge clk);
    total++;
    if (d_ready[2] !== 1'b1) begin
      bad++; $display("FAIL mid_issue_d got=%b exp=1", d_ready[2]);
    end
    next_cycle();
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if ({i_rvalid[2], d_rvalid[2]} !== 2'b00) begin
        bad++; $display("FAIL mid_dropped c=%0d got iv=%b dv=%b exp 0", c, i_rvalid[2], d_rvalid[2]);
      end
    end
    next_cycle();
    d_req[2] = 1; d_addr[2] = 32'h30;
    @(negedge clk);
    total++;
    if (d_ready[2] !== 1'b1) begin
      bad++; $display("FAIL mid_post_issue got=%b exp=1", d_ready[2]);
    end
    next_cycle();
    clear_inputs();
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      total++;
      if ({d_rvalid[2], d_rdata[2]} !== {(c == 3), (c == 3) ? 32'hCAFEF00D : 32'h0}) begin
        bad++; $display("FAIL mid_post_resp c=%0d got dv=%b dd=%h exp dv=%b", c, d_rvalid[2], d_rdata[2], (c == 3));
      end
      if (c < 3) next_cycle();
    end
  endtask

  task automatic test_random();
    logic conflict, exp_d, exp_i, ev, es, en;
    logic [31:0] ea, ed, er;
    logic [3:0]  ew;
    int slot;
    next_cycle();
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      starve[k] = 0; rr_i[k] = 1; acc_i[k] = 0; acc_d[k] = 0;
      for (int j = 0; j < 8; j++) rv[k][j] = 0;
    end
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < 3; k++) begin
        if (!i_req[k] || acc_i[k]) begin
          i_req[k] = ($urandom % 4) != 0; i_addr[k] = $urandom;
        end
        if (!d_req[k] || acc_d[k]) begin
          d_req[k] = ($urandom % 4) != 0; d_addr[k] = $urandom; d_wdata[k] = $urandom;
          d_we[k] = ($urandom % 2) ? 4'h0 : 4'($urandom_range(1, 15));
        end
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        conflict = i_req[k] & d_req[k];
        if (conflict) exp_d = dp_of(k) ? (starve[k] != sl_of(k)) : rr_i[k];
        else exp_d = d_req[k];
        exp_i = i_req[k] & !exp_d;
        en = i_req[k] | d_req[k];
        ea = exp_d ? {d_addr[k][31:2], 2'b00} : (exp_i ? {i_addr[k][31:2], 2'b00} : 32'h0);
        ed = exp_d ? d_wdata[k] : 32'h0;
        ew = exp_d ? d_we[k] : 4'h0;
        total++;
        if ({i_ready[k], d_ready[k]} !== {exp_i, exp_d}) begin
          bad++;
          $display("FAIL rnd_grant k=%0d cyc=%0d got i=%b d=%b exp i=%b d=%b", k, cyc, i_ready[k], d_ready[k], exp_i, exp_d);
        end
        total++;
        if ({mem_en[k], mem_addr[k], mem_d[k], mem_we[k]} !== {en, ea, ed, ew}) begin
          bad++;
          $display("FAIL rnd_mem k=%0d cyc=%0d got en=%b a=%h d=%h we=%h exp en=%b a=%h d=%h we=%h", k, cyc,
                   mem_en[k], mem_addr[k], mem_d[k], mem_we[k], en, ea, ed, ew);
        end
        slot = cyc % 8;
        ev = rv[k][slot]; es = rs[k][slot]; er = rd[k][slot];
        rv[k][slot] = 0;
        total++;
        if ({i_rvalid[k], d_rvalid[k], i_rdata[k], d_rdata[k]} !==
            {ev & !es, ev & es, (ev & !es) ? er : 32'h0, (ev & es) ? er : 32'h0}) begin
          bad++;
          $display("FAIL rnd_resp k=%0d cyc=%0d got iv=%b dv=%b id=%h dd=%h exp v=%b src_d=%b data=%h", k, cyc,
                   i_rvalid[k], d_rvalid[k], i_rdata[k], d_rdata[k], ev, es, er);
        end
        if (en) begin
          slot = (cyc + ml_of(k)) % 8;
          rv[k][slot] = 1; rs[k][slot] = exp_d;
          rd[k][slot] = (exp_d && d_we[k] != 0) ? 32'h0 : ram[k][ea[13:2]];
        end
        if (exp_i) starve[k] = 0;
        else if (conflict && starve[k] < sl_of(k)) starve[k]++;
        if (conflict) rr_i[k] = exp_i;
        acc_i[k] = exp_i; acc_d[k] = exp_d;
      end
      next_cycle();
    end
    clear_inputs();
    repeat (4) next_cycle();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 4096; j++) ram[k][j] = $urandom;
      for (int j = 0; j < 4; j++) qline[k][j] = 32'h0;
    end
    test_reset();
    test_solo_fetch();
    test_data_priority();
    test_round_robin();
    test_write_ack();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
